// File: rtl/serial_rx_frame.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_rx_frame
// UART 8N1 receiver that collects NUM_BYTES consecutive bytes (LSB-first on
// the wire, byte 0 in the low bits of the word) and presents the whole frame
// as one parallel word. A frame is discarded on a bad stop bit or when the
// idle gap between two bytes of the same frame exceeds GAP_TIMEOUT clocks.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   data       last complete frame, stable between new_data pulses
//   new_data   one-cycle pulse when data is updated
//   busy       high while a frame is partially received (state not IDLE)
//   frame_err  one-cycle pulse when a partial frame is discarded
// -----------------------------------------------------------------------------
module serial_rx_frame #(
  parameter int CLK_PER_BIT = 50,
  parameter int NUM_BYTES   = 6,
  parameter int GAP_TIMEOUT = 4 * CLK_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] data,
  output logic                   new_data,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int DW       = 8 * NUM_BYTES;
  localparam int HALF     = CLK_PER_BIT / 2;
  localparam int CTR_SIZE = $clog2(GAP_TIMEOUT + 1);
  localparam int BIDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CTR_SIZE-1:0] CTR_ZERO  = CTR_SIZE'(0);
  localparam logic [CTR_SIZE-1:0] CTR_ONE   = CTR_SIZE'(1);
  localparam logic [CTR_SIZE-1:0] HALF_M1   = CTR_SIZE'(HALF - 1);
  localparam logic [CTR_SIZE-1:0] BIT_M1    = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] GAP_MAX   = CTR_SIZE'(GAP_TIMEOUT);
  localparam logic [BIDX_W-1:0]   BIDX_ZERO = BIDX_W'(0);
  localparam logic [BIDX_W-1:0]   BIDX_ONE  = BIDX_W'(1);
  localparam logic [BIDX_W-1:0]   LAST_BYTE = BIDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_GAP       = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic              r_rx_meta;
  logic              r_rx_s;
  state_t            r_state;
  logic [CTR_SIZE-1:0] r_ctr;
  logic [CTR_SIZE-1:0] r_gap;
  logic [2:0]        r_bit_idx;
  logic [BIDX_W-1:0] r_byte_idx;
  logic [7:0]        r_byte;
  logic [DW-1:0]     r_word;
  logic [DW-1:0]     r_data;
  logic              r_new_data;
  logic              r_frame_err;
  logic              r_busy;

  state_t            w_state_next;
  logic [CTR_SIZE-1:0] w_ctr_next;
  logic [CTR_SIZE-1:0] w_gap_next;
  logic [CTR_SIZE-1:0] w_gap_inc;
  logic [2:0]        w_bit_idx_next;
  logic [BIDX_W-1:0] w_byte_idx_next;
  logic [7:0]        w_byte_next;
  logic [DW-1:0]     w_word_next;
  logic [DW-1:0]     w_word_full;
  logic [DW-1:0]     w_data_next;
  logic              w_new_data_next;
  logic              w_frame_err_next;

  assign data      = r_data;
  assign new_data  = r_new_data;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

  // Two-flop synchronizer for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Partially assembled word with the byte just received merged into its slot.
  always_comb begin
    w_word_full = r_word;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (r_byte_idx == BIDX_W'(k)) begin
        w_word_full[8*k +: 8] = r_byte;
      end else begin
        w_word_full[8*k +: 8] = r_word[8*k +: 8];
      end
    end
  end

  // Next-state and datapath decode of the receive FSM.
  always_comb begin
    w_state_next     = r_state;
    w_ctr_next       = r_ctr;
    w_gap_next       = r_gap;
    w_bit_idx_next   = r_bit_idx;
    w_byte_idx_next  = r_byte_idx;
    w_byte_next      = r_byte;
    w_word_next      = r_word;
    w_data_next      = r_data;
    w_new_data_next  = 1'b0;
    w_frame_err_next = 1'b0;
    // Saturating, so a long glitch cannot wrap the gap count past the limit.
    w_gap_inc = (r_gap == GAP_MAX) ? r_gap : (r_gap + CTR_ONE);

    case (r_state)
      S_IDLE: begin
        w_byte_idx_next = BIDX_ZERO;
        if (!r_rx_s) begin
          w_state_next = S_START;
          w_ctr_next   = CTR_ZERO;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_START: begin
        // Glitch time keeps counting toward the inter-byte timeout.
        w_gap_next = w_gap_inc;
        if (r_ctr == HALF_M1) begin
          if (!r_rx_s) begin
            w_state_next   = S_DATA;
            w_ctr_next     = CTR_ZERO;
            w_bit_idx_next = 3'd0;
          end else if (r_byte_idx == BIDX_ZERO) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_GAP;
          end
        end else begin
          w_ctr_next = r_ctr + CTR_ONE;
        end
      end

      S_DATA: begin
        if (r_ctr == BIT_M1) begin
          // LSB arrives first, so shift in from the top.
          w_byte_next = {r_rx_s, r_byte[7:1]};
          w_ctr_next  = CTR_ZERO;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_ctr_next = r_ctr + CTR_ONE;
        end
      end

      S_STOP: begin
        if (r_ctr == BIT_M1) begin
          w_ctr_next = CTR_ZERO;
          if (!r_rx_s) begin
            w_frame_err_next = 1'b1;
            w_byte_idx_next  = BIDX_ZERO;
            w_state_next     = S_WAIT_HIGH;
          end else if (r_byte_idx == LAST_BYTE) begin
            w_data_next     = w_word_full;
            w_new_data_next = 1'b1;
            w_byte_idx_next = BIDX_ZERO;
            w_state_next    = S_IDLE;
          end else begin
            w_word_next     = w_word_full;
            w_byte_idx_next = r_byte_idx + BIDX_ONE;
            w_gap_next      = CTR_ZERO;
            w_state_next    = S_GAP;
          end
        end else begin
          w_ctr_next = r_ctr + CTR_ONE;
        end
      end

      S_GAP: begin
        w_gap_next = w_gap_inc;
        // A start edge takes priority over a simultaneous timeout.
        if (!r_rx_s) begin
          w_state_next = S_START;
          w_ctr_next   = CTR_ZERO;
        end else if (w_gap_inc == GAP_MAX) begin
          w_frame_err_next = 1'b1;
          w_byte_idx_next  = BIDX_ZERO;
          w_state_next     = S_IDLE;
        end else begin
          w_state_next = S_GAP;
        end
      end

      S_WAIT_HIGH: begin
        // Hold off until the line is released so a break is not decoded.
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT_HIGH;
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_byte_idx_next = BIDX_ZERO;
      end
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ctr       <= CTR_ZERO;
      r_gap       <= CTR_ZERO;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= BIDX_ZERO;
      r_byte      <= 8'h00;
      r_word      <= {DW{1'b0}};
      r_data      <= {DW{1'b0}};
      r_new_data  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ctr       <= w_ctr_next;
      r_gap       <= w_gap_next;
      r_bit_idx   <= w_bit_idx_next;
      r_byte_idx  <= w_byte_idx_next;
      r_byte      <= w_byte_next;
      r_word      <= w_word_next;
      r_data      <= w_data_next;
      r_new_data  <= w_new_data_next;
      r_frame_err <= w_frame_err_next;
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_rx_frame.sv
`timescale 1ns/1ps
// Self-checking bench for serial_rx_frame: drives 8N1 serial frames with
// random payloads and gaps, and compares received words and pulse counts
// against a queue of expected frames built from the transmitted bytes.
module tb_serial_rx_frame;

  localparam int CPB = 50;
  localparam int NB  = 6;
  localparam int GT  = 4 * CPB;
  localparam int DW  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DW-1:0] data;
  logic          new_data;
  logic          busy;
  logic          frame_err;

  serial_rx_frame #(
    .CLK_PER_BIT(CPB),
    .NUM_BYTES  (NB),
    .GAP_TIMEOUT(GT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .new_data (new_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            nd_count = 0;
  int            fe_count = 0;
  int            exp_nd = 0;
  int            exp_fe = 0;
  int            nd_cyc[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_good = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Pulse monitor: scoreboard for received frames and pulse properties.
  always @(negedge clk) begin
    if (!rst) begin
      if (new_data) begin
        nd_count++;
        nd_cyc.push_back(cyc);
        check_eq("nd_busy_low", busy, 1'b0);
        check_eq("nd_fe_excl", frame_err, 1'b0);
        check_eq("nd_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          last_good = exp_q.pop_front();
          check_eq("nd_data", data, last_good);
        end
      end
      if (frame_err) fe_count++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cyc(n);
  endtask

  // Sends a complete valid frame and records it as expected output.
  task automatic send_frame(input logic [DW-1:0] w, input int gap_max);
    exp_q.push_back(w);
    exp_nd++;
    for (int k = 0; k < NB; k++) begin
      send_byte(w[8*k +: 8], 1'b1);
      if (k < NB - 1 && gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_nd_count"}, nd_count, exp_nd);
    check_eq({tag, "_fe_count"}, fe_count, exp_fe);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] prev;
    logic          saw_busy;
    int            d;

    // Reset values
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    check_eq("rst_data", data, '0);
    check_eq("rst_new_data", new_data, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    idle(20);

    // Fixed back-to-back frame
    send_frame(48'h665544332211, 0);
    idle(10);
    check_counts("fixed");
    check_eq("fixed_data", data, 48'h665544332211);

    // Two frames with no inter-frame gap
    send_frame('0, 0);
    send_frame('1, 0);
    idle(10);
    check_counts("b2b");
    d = (nd_cyc.size() >= 2) ? (nd_cyc[nd_cyc.size()-1] - nd_cyc[nd_cyc.size()-2]) : 0;
    check_eq("b2b_spacing_ok", (d >= 2998 && d <= 3002), 1'b1);
    check_eq("b2b_data", data, {DW{1'b1}});

    // Bad stop bit on byte 3, then a break held low
    prev = last_good;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    exp_fe++;
    rx = 1'b0;
    wait_cyc(200);
    check_counts("stoperr");
    check_eq("stoperr_busy_break", busy, 1'b1);
    check_eq("stoperr_data_kept", data, prev);
    idle(100);
    check_eq("stoperr_busy_idle", busy, 1'b0);
    send_frame(rand_word(), 0);
    idle(10);
    check_counts("stoperr_recover");

    // Gap timeout after byte 2
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    check_eq("gap_busy_mid", busy, 1'b1);
    exp_fe++;
    idle(201);
    check_counts("gap");
    check_eq("gap_busy", busy, 1'b0);
    send_frame(rand_word(), 0);
    idle(10);
    check_counts("gap_recover");

    // Short low glitch on an idle line
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check_eq("glitch_saw_start", saw_busy, 1'b1);
    check_eq("glitch_busy", busy, 1'b0);
    idle(20);
    check_counts("glitch");

    // Reset in the middle of byte 4
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_data", data, '0);
    check_eq("midrst_new_data", new_data, 1'b0);
    check_eq("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    last_good = '0;
    idle(20);
    check_counts("midrst");
    send_frame(rand_word(), 0);
    idle(10);
    check_counts("midrst_recover");

    // Random frames with random intra-frame gaps below the timeout
    for (int f = 0; f < 4; f++) begin
      send_frame(rand_word(), 150);
      idle(int'($urandom_range(100, 0)));
    end
    idle(20);
    check_counts("rand");
    check_eq("rand_queue_drained", exp_q.size(), 0);
    check_eq("final_data", data, last_good);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
